// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral bus. Each transaction
// runs a fixed ISSUE/CAPTURE/RESP sequence and the bus is driven idle-clean at all other times.
module periph_bus_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    output logic        m0_gnt,
    output logic        m0_done,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic        per_we,
    input  logic [31:0] per_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t      state_q;
    logic        prio_q;
    logic        owner_q;
    logic        m0_gnt_q, m1_gnt_q;
    logic        m0_done_q, m1_done_q;
    logic        busy_q;
    logic [31:0] rdata_q;
    logic [31:0] per_addr_q, per_wdata_q;
    logic        per_we_q;

    logic        grant_d;
    logic        owner_d;
    logic [31:0] addr_d, wdata_d;
    logic        we_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant_d = m0_req | m1_req;
        owner_d = prio_q;
        if (m0_req && !m1_req) begin
            owner_d = 1'b0;
        end else if (m1_req && !m0_req) begin
            owner_d = 1'b1;
        end
        addr_d  = owner_d ? m1_addr  : m0_addr;
        wdata_d = owner_d ? m1_wdata : m0_wdata;
        we_d    = owner_d ? m1_we    : m0_we;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_INIT;
            owner_q     <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            per_addr_q  <= '0;
            per_wdata_q <= '0;
            per_we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= ISSUE;
                        owner_q     <= owner_d;
                        prio_q      <= ~owner_d;
                        m0_gnt_q    <= ~owner_d;
                        m1_gnt_q    <= owner_d;
                        busy_q      <= 1'b1;
                        per_addr_q  <= addr_d;
                        per_wdata_q <= wdata_d;
                        per_we_q    <= we_d;
                    end
                end
                ISSUE: begin
                    state_q     <= CAPTURE;
                    per_addr_q  <= '0;
                    per_wdata_q <= '0;
                    per_we_q    <= 1'b0;
                end
                CAPTURE: begin
                    state_q   <= RESP;
                    rdata_q   <= per_rdata;
                    m0_done_q <= ~owner_q;
                    m1_done_q <= owner_q;
                end
                RESP: begin
                    state_q   <= IDLE;
                    m0_gnt_q  <= 1'b0;
                    m1_gnt_q  <= 1'b0;
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    busy_q    <= 1'b0;
                    rdata_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign busy      = busy_q;
    assign rdata     = rdata_q;
    assign per_addr  = per_addr_q;
    assign per_wdata = per_wdata_q;
    assign per_we    = per_we_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level timing model.
module tb_periph_bus_arbiter;

    localparam bit PRIO_INIT = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] per_addr, per_wdata;
    logic        per_we;
    logic [31:0] per_rdata = '0;

    int checkCount = 0;
    int failCount  = 0;
    int cycleNo    = 0;

    // Reference model: remembers the edge at which the current transaction was
    // granted; every output follows from the offset of the current cycle from it.
    bit          mActive     = 1'b0;
    int          mGrantCycle = 0;
    bit          mOwner      = 1'b0;
    bit          mPtr        = PRIO_INIT;
    logic [31:0] mAddr       = '0;
    logic [31:0] mWdata      = '0;
    bit          mWe         = 1'b0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_we    (m0_we),
        .m0_gnt   (m0_gnt),
        .m0_done  (m0_done),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m1_gnt   (m1_gnt),
        .m1_done  (m1_done),
        .rdata    (rdata),
        .busy     (busy),
        .per_addr (per_addr),
        .per_wdata(per_wdata),
        .per_we   (per_we),
        .per_rdata(per_rdata)
    );

    // Peripheral stub: registered read data, zero on writes.
    function automatic logic [31:0] stubFn(input logic [31:0] a);
        if (a == 32'h4000_0001) return 32'h0000_0007;
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) per_rdata <= per_we ? 32'h0 : stubFn(per_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycleNo, observed, expected);
        end
    endtask

    task automatic modelStep();
        if (!reset_n) begin
            mActive = 1'b0;
            mPtr    = PRIO_INIT;
        end else if (!mActive || (cycleNo - mGrantCycle) >= 4) begin
            mActive = 1'b0;
            if (m0_req || m1_req) begin
                mOwner      = (m0_req && m1_req) ? mPtr : m1_req;
                mPtr        = !mOwner;
                mActive     = 1'b1;
                mGrantCycle = cycleNo;
                mAddr       = mOwner ? m1_addr  : m0_addr;
                mWdata      = mOwner ? m1_wdata : m0_wdata;
                mWe         = mOwner ? m1_we    : m0_we;
            end
        end
    endtask

    task automatic checkAll();
        int          off;
        bit          inWin, issue, resp;
        logic [31:0] expRdata;
        off      = cycleNo - mGrantCycle;
        inWin    = mActive && (off <= 2);
        issue    = mActive && (off == 0);
        resp     = mActive && (off == 2);
        expRdata = (resp && !mWe) ? stubFn(mAddr) : 32'h0;
        checkOutput("m0_gnt",    32'(m0_gnt),    32'(inWin && !mOwner));
        checkOutput("m1_gnt",    32'(m1_gnt),    32'(inWin && mOwner));
        checkOutput("gntOverlap", 32'(m0_gnt & m1_gnt), 32'h0);
        checkOutput("m0_done",   32'(m0_done),   32'(resp && !mOwner));
        checkOutput("m1_done",   32'(m1_done),   32'(resp && mOwner));
        checkOutput("busy",      32'(busy),      32'(inWin));
        checkOutput("rdata",     rdata,          expRdata);
        checkOutput("per_addr",  per_addr,       issue ? mAddr : 32'h0);
        checkOutput("per_wdata", per_wdata,      issue ? mWdata : 32'h0);
        checkOutput("per_we",    32'(per_we),    32'(issue && mWe));
    endtask

    task automatic applyStimulus(input bit rstn,
                                 input bit r0, input logic [31:0] a0, input logic [31:0] w0, input bit we0,
                                 input bit r1, input logic [31:0] a1, input logic [31:0] w1, input bit we1);
        reset_n  = rstn;
        m0_req   = r0;  m0_addr = a0;  m0_wdata = w0;  m0_we = we0;
        m1_req   = r1;  m1_addr = a1;  m1_wdata = w1;  m1_we = we1;
        @(posedge clk);
        cycleNo++;
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        bit          hold0, hold1, rst;
        logic [31:0] a0, w0, a1, w1;
        bit          we0, we1;
        int          strobes;

        reset_n = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = 1'b0;

        // Reset held with both masters requesting.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 32'h6000_0010, 32'h11, 1, 1, 32'h8000_0020, 32'h22, 0);

        // Release into continuous contention: m0 first, then alternating.
        applyStimulus(1, 1, 32'h6000_0010, 32'h11, 1, 1, 32'h8000_0020, 32'h22, 0);
        checkOutput("rstReleaseOwner", 32'(m0_gnt), 32'h1);
        for (int i = 0; i < 15; i++)
            applyStimulus(1, 1, 32'h6000_0010, 32'h11, 1, 1, 32'h8000_0020, 32'h22, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Single write from m0.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 32'h2000_0000, 32'h5, 1, 0, '0, '0, 0);
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Single read from m1, stub returns 7.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, '0, '0, 0, 1, 32'h4000_0001, 32'h0, 0);
        checkOutput("readRdata", rdata, 32'h7);
        applyStimulus(1, 0, '0, '0, 0, 1, 32'h4000_0001, 32'h0, 0);
        checkOutput("readRdataCleared", rdata, 32'h0);
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Reset during CAPTURE after a lone m0 grant moved the pointer to m1.
        applyStimulus(1, 1, 32'hA000_0004, 32'h33, 0, 0, '0, '0, 0);
        applyStimulus(1, 1, 32'hA000_0004, 32'h33, 0, 0, '0, '0, 0);
        applyStimulus(0, 1, 32'hA000_0004, 32'h33, 0, 0, '0, '0, 0);
        checkOutput("midResetDone", 32'(m0_done), 32'h0);
        applyStimulus(1, 1, 32'hA000_0008, 32'h44, 0, 1, 32'hC000_0008, 32'h55, 1);
        checkOutput("midResetOwner", 32'(m0_gnt), 32'h1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Back-to-back reads to the button counter: one strobe per transaction.
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 32'h4000_0000, 32'h0, 0, 0, '0, '0, 0);
            if (per_addr[31:29] == 3'b010) strobes++;
        end
        checkOutput("strobeCount", 32'(strobes), 32'd3);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, '0, '0, 0, 0, '0, '0, 0);

        // Randomized traffic, including dropped requests and stray resets.
        hold0 = 0; hold1 = 0;
        a0 = '0; w0 = '0; we0 = 0; a1 = '0; w1 = '0; we1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold0 && m0_done) begin
                hold0 = ($urandom % 2) == 0;
                a0 = $urandom; w0 = $urandom; we0 = $urandom % 2;
            end else if (hold0 && m0_gnt && ($urandom % 50) == 0) begin
                hold0 = 0;
            end else if (!hold0 && ($urandom % 4) == 0) begin
                hold0 = 1;
                a0 = $urandom; w0 = $urandom; we0 = $urandom % 2;
            end
            if (hold1 && m1_done) begin
                hold1 = ($urandom % 2) == 0;
                a1 = $urandom; w1 = $urandom; we1 = $urandom % 2;
            end else if (hold1 && m1_gnt && ($urandom % 50) == 0) begin
                hold1 = 0;
            end else if (!hold1 && ($urandom % 4) == 0) begin
                hold1 = 1;
                a1 = $urandom; w1 = $urandom; we1 = $urandom % 2;
            end
            rst = ($urandom % 150) != 0;
            applyStimulus(rst, hold0, a0, w0, we0, hold1, a1, w1, we1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
